// File: rtl/osd_sched.sv
`default_nettype none
// ============================================================================
// Module      : osd_sched
// Description : Frame-synchronous OSD scheduler. Decides when the OSD
//               datapath draws (logo + window, window only, or nothing) and
//               arbitrates between the NIOSII menu level and short
//               status-message requests. The menu has priority over messages.
//               Visibility changes are applied only at frame boundaries.
//
// Ports       : VCLK        video clock
//               nVRST       asynchronous active-low reset
//               nVDSYNC     data strobe (low = valid); qualifies vsync sampling
//               nVSYNC_i    vertical sync from the video bus, active-low
//               menu_req    menu-open level (async to VCLK)
//               msg_req     message request, four-phase handshake (async)
//               msg_frames  message duration in frames, 0 = MSG_DEFAULT
//               msg_ack     handshake acknowledge
//               OSDInfo     [1] show_osd_logo, [0] show_osd (registered)
//               osd_busy    high whenever the scheduler is not IDLE
//               frame_tick  one-cycle pulse per detected frame boundary
//
// Build macro : OSD_BOOT_LOGO_EN - when defined, reset enters a BOOT state
//               that shows logo and window for LOGO_FRAMES frames. When
//               undefined, reset enters IDLE and LOGO_FRAMES is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module osd_sched #(
  parameter logic [7:0] LOGO_FRAMES = 8'd120,
  parameter logic [7:0] MSG_DEFAULT = 8'd60
) (
  input  logic       VCLK,
  input  logic       nVRST,
  input  logic       nVDSYNC,
  input  logic       nVSYNC_i,
  input  logic       menu_req,
  input  logic       msg_req,
  input  logic [7:0] msg_frames,
  output logic       msg_ack,
  output logic [1:0] OSDInfo,
  output logic       osd_busy,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MENU = 2'd1,
`ifdef OSD_BOOT_LOGO_EN
    ST_BOOT = 2'd3,
`endif
    ST_MSG  = 2'd2
  } state_t;

`ifdef OSD_BOOT_LOGO_EN
  localparam state_t     C_ST_RESET   = ST_BOOT;
  localparam logic [7:0] C_CNT_RESET  = LOGO_FRAMES;
  localparam logic [1:0] C_INFO_RESET = 2'b11;
`else
  localparam state_t     C_ST_RESET   = ST_IDLE;
  localparam logic [7:0] C_CNT_RESET  = 8'd0;
  localparam logic [1:0] C_INFO_RESET = 2'b00;
  // Logo duration has no meaning without the BOOT state.
  logic w_unused_logo;
  assign w_unused_logo = ^LOGO_FRAMES;
`endif

  // --------------------------------------------------------------------------
  // Synchronisers for the two asynchronous control inputs
  // --------------------------------------------------------------------------
  logic r_menu_meta, r_menu_s;
  logic r_req_meta,  r_req_s;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      r_menu_meta <= 1'b0;
      r_menu_s    <= 1'b0;
      r_req_meta  <= 1'b0;
      r_req_s     <= 1'b0;
    end else begin
      r_menu_meta <= menu_req;
      r_menu_s    <= r_menu_meta;
      r_req_meta  <= msg_req;
      r_req_s     <= r_req_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Frame boundary detection. The previous sample resets to 0 so the first
  // strobe-qualified sample after reset can never look like a falling edge.
  // --------------------------------------------------------------------------
  logic r_vs_prev;
  logic r_tick;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (!nVDSYNC) begin
        r_vs_prev <= nVSYNC_i;
        r_tick    <= r_vs_prev & ~nVSYNC_i;
      end
    end
  end

  assign frame_tick = r_tick;

  // --------------------------------------------------------------------------
  // Message handshake
  // --------------------------------------------------------------------------
  logic       r_ack;
  logic       r_pend;
  logic [7:0] r_len;
  logic       w_accept;
  logic       w_consume;

  assign w_accept = r_req_s & ~r_ack;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      r_ack  <= 1'b0;
      r_pend <= 1'b0;
      r_len  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_ack <= 1'b1;
      end else if (!r_req_s) begin
        r_ack <= 1'b0;
      end
      // A request accepted in the same cycle the FSM consumes the older one
      // must survive, so acceptance wins over consumption.
      if (w_accept) begin
        r_pend <= 1'b1;
        r_len  <= msg_frames;
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign msg_ack = r_ack;

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] w_cnt_dec;
  logic [7:0] w_msg_load;
  logic [1:0] r_info, w_info_nxt;

  assign w_cnt_dec  = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
  assign w_msg_load = (r_len == 8'd0) ? MSG_DEFAULT : r_len;

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      r_state <= C_ST_RESET;
      r_cnt   <= C_CNT_RESET;
      r_info  <= C_INFO_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_info  <= w_info_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_consume   = 1'b0;
    if (r_tick) begin
      w_cnt_nxt = w_cnt_dec;
      case (r_state)
`ifdef OSD_BOOT_LOGO_EN
        ST_BOOT: begin
          if (r_menu_s) begin
            w_state_nxt = ST_MENU;
            w_cnt_nxt   = 8'd0;
            w_consume   = 1'b1;
          end else if (r_cnt <= 8'd1) begin
            // Counter hits 0 on this tick: logo shown for LOGO_FRAMES ticks.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end
`endif
        ST_MENU: begin
          // Messages arriving while the menu is open are discarded.
          w_consume = 1'b1;
          if (!r_menu_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end
        ST_MSG: begin
          if (r_menu_s) begin
            w_state_nxt = ST_MENU;
            w_cnt_nxt   = 8'd0;
            w_consume   = 1'b1;
          end else if (r_pend) begin
            w_cnt_nxt = w_msg_load;
            w_consume = 1'b1;
          end else if (r_cnt <= 8'd1) begin
            // Leaving on count 1 makes an N-frame message last N ticks.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end
        end
        default: begin // ST_IDLE
          if (r_menu_s) begin
            w_state_nxt = ST_MENU;
            w_cnt_nxt   = 8'd0;
            w_consume   = 1'b1;
          end else if (r_pend) begin
            w_state_nxt = ST_MSG;
            w_cnt_nxt   = w_msg_load;
            w_consume   = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_info_nxt = 2'b00;
    case (w_state_nxt)
`ifdef OSD_BOOT_LOGO_EN
      ST_BOOT: w_info_nxt = 2'b11;
`endif
      ST_MENU: w_info_nxt = 2'b11;
      ST_MSG:  w_info_nxt = 2'b01;
      default: w_info_nxt = 2'b00;
    endcase
  end

  assign OSDInfo  = r_info;
  assign osd_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_osd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_sched
// Description : Self-checking bench for osd_sched. Directed scenarios plus a
//               randomized section, all checked against a frame-level
//               behavioural model of the scheduler. Follows OSD_BOOT_LOGO_EN
//               the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_sched;

`ifdef OSD_BOOT_LOGO_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif
  localparam int LOGO = 3;

  localparam int M_IDLE = 0;
  localparam int M_BOOT = 1;
  localparam int M_MENU = 2;
  localparam int M_MSG  = 3;

  logic       VCLK = 1'b0;
  logic       nVRST;
  logic       nVDSYNC;
  logic       nVSYNC_i;
  logic       menu_req;
  logic       msg_req;
  logic [7:0] msg_frames;
  logic       msg_ack;
  logic [1:0] OSDInfo;
  logic       osd_busy;
  logic       frame_tick;

  osd_sched #(
    .LOGO_FRAMES (8'(LOGO)),
    .MSG_DEFAULT (8'd60)
  ) dut (
    .VCLK       (VCLK),
    .nVRST      (nVRST),
    .nVDSYNC    (nVDSYNC),
    .nVSYNC_i   (nVSYNC_i),
    .menu_req   (menu_req),
    .msg_req    (msg_req),
    .msg_frames (msg_frames),
    .msg_ack    (msg_ack),
    .OSDInfo    (OSDInfo),
    .osd_busy   (osd_busy),
    .frame_tick (frame_tick)
  );

  always #5 VCLK = ~VCLK;

  int total = 0;
  int bad   = 0;

  // Frame-level model: what is on screen, frames left, and the pending message.
  int m_st, m_left, m_pend, m_len;
  bit m_menu;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_info();
    case (m_st)
      M_BOOT, M_MENU: return 2'b11;
      M_MSG:          return 2'b01;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic exp_busy();
    return (m_st != M_IDLE);
  endfunction

  task automatic model_reset();
    m_st   = BOOT_EN ? M_BOOT : M_IDLE;
    m_left = LOGO;
    m_pend = 0;
    m_len  = 0;
    m_menu = 1'b0;
  endtask

  task automatic model_tick();
    int nl;
    nl = (m_len == 0) ? 60 : m_len;
    if (m_st == M_MENU) begin
      m_pend = 0;
      if (!m_menu) m_st = M_IDLE;
    end else if (m_menu) begin
      m_st   = M_MENU;
      m_pend = 0;
    end else if (m_st == M_BOOT) begin
      m_left = m_left - 1;
      if (m_left == 0) m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (m_pend != 0) begin
        m_st = M_MSG; m_left = nl; m_pend = 0;
      end
    end else begin
      if (m_pend != 0) begin
        m_left = nl; m_pend = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) m_st = M_IDLE;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge VCLK);
  endtask

  // One vsync falling edge with the strobe active; checks the tick pulse and
  // that OSDInfo only moves the cycle after it.
  task automatic do_frame(input string tag);
    @(negedge VCLK) nVSYNC_i = 1'b0;
    @(negedge VCLK);
    chk({tag, ".tick"}, {7'd0, frame_tick}, 8'd1);
    chk({tag, ".hold"}, {6'd0, OSDInfo}, {6'd0, exp_info()});
    model_tick();
    @(negedge VCLK);
    chk({tag, ".tick_off"}, {7'd0, frame_tick}, 8'd0);
    chk({tag, ".info"}, {6'd0, OSDInfo}, {6'd0, exp_info()});
    chk({tag, ".busy"}, {7'd0, osd_busy}, {7'd0, exp_busy()});
    nVSYNC_i = 1'b1;
    cyc(2);
  endtask

  task automatic send_msg(input string tag, input logic [7:0] n);
    msg_frames = n;
    msg_req    = 1'b1;
    cyc(4);
    chk({tag, ".ack_hi"}, {7'd0, msg_ack}, 8'd1);
    m_pend = 1;
    m_len  = n;
    msg_req = 1'b0;
    cyc(4);
    chk({tag, ".ack_lo"}, {7'd0, msg_ack}, 8'd0);
  endtask

  task automatic set_menu(input logic v);
    menu_req = v;
    cyc(4);
    m_menu = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    nVRST = 1'b0; nVDSYNC = 1'b0; nVSYNC_i = 1'b1;
    menu_req = 1'b0; msg_req = 1'b0; msg_frames = 8'd0;
    model_reset();
    cyc(3);
    chk("rst.info", {6'd0, OSDInfo}, {6'd0, exp_info()});
    chk("rst.busy", {7'd0, osd_busy}, {7'd0, exp_busy()});
    chk("rst.ack",  {7'd0, msg_ack}, 8'd0);
    chk("rst.tick", {7'd0, frame_tick}, 8'd0);
    nVRST = 1'b1;
    cyc(3);
    chk("rst.no_first_tick", {7'd0, frame_tick}, 8'd0);

    // Boot logo (or plain idle frames in the default build)
    for (int i = 0; i < 4; i++) do_frame("boot");

    // Five-frame message
    send_msg("msg5", 8'd5);
    for (int i = 0; i < 7; i++) do_frame("msg5");

    // Menu pre-empts a running message and never returns to it
    send_msg("pre", 8'd6);
    for (int i = 0; i < 3; i++) do_frame("pre.msg");
    set_menu(1'b1);
    do_frame("pre.menu");
    set_menu(1'b0);
    do_frame("pre.close");
    do_frame("pre.after");

    // Mid-frame menu change waits for the frame boundary; vsync edges while
    // the strobe is inactive are ignored.
    menu_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge VCLK);
      chk("align.hold", {6'd0, OSDInfo}, {6'd0, exp_info()});
    end
    nVDSYNC = 1'b1;
    nVSYNC_i = 1'b0;
    cyc(2);
    chk("align.strobe_lo", {7'd0, frame_tick}, 8'd0);
    nVSYNC_i = 1'b1;
    cyc(2);
    chk("align.strobe_hi", {7'd0, frame_tick}, 8'd0);
    nVDSYNC = 1'b0;
    cyc(2);
    chk("align.no_tick", {6'd0, OSDInfo}, {6'd0, exp_info()});
    m_menu = 1'b1;
    do_frame("align.menu");
    set_menu(1'b0);
    do_frame("align.close");

    // Acceptance in the same cycle as frame_tick: taken one frame later
    @(negedge VCLK) begin msg_frames = 8'd3; msg_req = 1'b1; end
    @(negedge VCLK) nVSYNC_i = 1'b0;
    @(negedge VCLK);
    chk("simul.tick", {7'd0, frame_tick}, 8'd1);
    model_tick();
    m_pend = 1; m_len = 3;
    @(negedge VCLK);
    chk("simul.info", {6'd0, OSDInfo}, {6'd0, exp_info()});
    chk("simul.ack",  {7'd0, msg_ack}, 8'd1);
    nVSYNC_i = 1'b1;
    msg_req  = 1'b0;
    cyc(4);
    chk("simul.ack_lo", {7'd0, msg_ack}, 8'd0);
    do_frame("simul.take");

    // Retrigger with two frames left and msg_frames = 0 (default length)
    do_frame("retrig.pre");
    send_msg("retrig", 8'd0);
    for (int i = 0; i < 62; i++) do_frame("retrig");

    // Randomized mix of menu toggles, messages and frames
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) set_menu(~menu_req);
      else if (r < 6) send_msg("rnd.msg", 8'($urandom_range(0, 6)));
      do_frame("rnd");
    end
    set_menu(1'b0);

    // Asynchronous reset while the menu is open and an ack is high
    set_menu(1'b1);
    do_frame("areset.menu");
    msg_frames = 8'd2;
    msg_req = 1'b1;
    cyc(4);
    chk("areset.ack_pre", {7'd0, msg_ack}, 8'd1);
    @(negedge VCLK);
    #2 nVRST = 1'b0;
    #1;
    model_reset();
    chk("areset.info", {6'd0, OSDInfo}, {6'd0, exp_info()});
    chk("areset.ack",  {7'd0, msg_ack}, 8'd0);
    chk("areset.busy", {7'd0, osd_busy}, {7'd0, exp_busy()});
    menu_req = 1'b0;
    msg_req  = 1'b0;
    cyc(2);
    nVRST = 1'b1;
    cyc(3);
    do_frame("areset.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
